// File: rtl/mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// mux_scan_ctrl
//   Steps the select lines of a 4-to-1 mux through channels 0..3. For each
//   channel it holds the select for SETTLE cycles and then samples the mux
//   output for one cycle. The four samples are assembled into a 4-bit word
//   and offered on a valid/ready interface. In continuous mode scans run
//   back to back. A completed word that cannot be delivered because the
//   previous word is still pending is dropped and flagged on a sticky overrun.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous reset, active low
//   start      in   single-scan request, sampled only while idle
//   cont       in   continuous scanning while high
//   sel_a      out  mux select a (channel index bit 1)
//   sel_b      out  mux select b (channel index bit 0)
//   mux_in     in   mux output, synchronous to clk
//   scan_data  out  assembled word, bit n = channel n sample
//   scan_valid out  scan_data holds an unconsumed word
//   scan_ready in   consumer accepts the word when scan_valid is high
//   busy       out  scan in progress
//   overrun    out  sticky, a completed word was dropped
// -----------------------------------------------------------------------------
module mux_scan_ctrl #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cont,
    output logic       sel_a,
    output logic       sel_b,
    input  logic       mux_in,
    output logic [3:0] scan_data,
    output logic       scan_valid,
    input  logic       scan_ready,
    output logic       busy,
    output logic       overrun
);

    if ((SETTLE < 1) || (SETTLE > 255)) begin : g_settle_range
        $error("mux_scan_ctrl: SETTLE must be within 1..255");
    end

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2
    } state_t;

    state_t     state_r, state_s;
    logic [1:0] ch_r, ch_s;
    logic [7:0] cnt_r, cnt_s;
    logic [2:0] shadow_r, shadow_s;
    logic [3:0] data_r, data_s;
    logic       valid_r, valid_s;
    logic       overrun_r, overrun_s;
    logic [3:0] word_s;

    // Next-state, channel sequencing, capture and output handshake
    always_comb begin
        state_s   = state_r;
        ch_s      = ch_r;
        cnt_s     = cnt_r;
        shadow_s  = shadow_r;
        data_s    = data_r;
        overrun_s = overrun_r;
        // Channel 3 is never stored in the shadow; it joins the word directly
        word_s    = {mux_in, shadow_r};

        // A pending word is consumed at any edge where ready is high
        if (valid_r && scan_ready) begin
            valid_s = 1'b0;
        end else begin
            valid_s = valid_r;
        end

        case (state_r)
            ST_IDLE: begin
                ch_s  = 2'd0;
                cnt_s = 8'd0;
                if (start || cont) begin
                    state_s = ST_SETTLE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_r == SETTLE_LAST) begin
                    state_s = ST_SAMPLE;
                    cnt_s   = 8'd0;
                end else begin
                    state_s = ST_SETTLE;
                    cnt_s   = cnt_r + 8'd1;
                end
            end
            ST_SAMPLE: begin
                cnt_s = 8'd0;
                case (ch_r)
                    2'd0: begin
                        shadow_s[0] = mux_in;
                        ch_s        = 2'd1;
                        state_s     = ST_SETTLE;
                    end
                    2'd1: begin
                        shadow_s[1] = mux_in;
                        ch_s        = 2'd2;
                        state_s     = ST_SETTLE;
                    end
                    2'd2: begin
                        shadow_s[2] = mux_in;
                        ch_s        = 2'd3;
                        state_s     = ST_SETTLE;
                    end
                    default: begin
                        // Word complete: deliver if the slot is free or being
                        // emptied at this very edge, otherwise drop it
                        if (!valid_r || scan_ready) begin
                            data_s  = word_s;
                            valid_s = 1'b1;
                        end else begin
                            overrun_s = 1'b1;
                        end
                        ch_s = 2'd0;
                        if (cont) begin
                            state_s = ST_SETTLE;
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end
                endcase
            end
            default: begin
                state_s = ST_IDLE;
                ch_s    = 2'd0;
                cnt_s   = 8'd0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            ch_r      <= 2'd0;
            cnt_r     <= 8'd0;
            shadow_r  <= 3'd0;
            data_r    <= 4'd0;
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            ch_r      <= ch_s;
            cnt_r     <= cnt_s;
            shadow_r  <= shadow_s;
            data_r    <= data_s;
            valid_r   <= valid_s;
            overrun_r <= overrun_s;
        end
    end

    assign sel_a      = ch_r[1];
    assign sel_b      = ch_r[0];
    assign scan_data  = data_r;
    assign scan_valid = valid_r;
    assign busy       = (state_r != ST_IDLE);
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_ctrl
//   Directed bench for mux_scan_ctrl with SETTLE=2. A behavioural 4-to-1 mux
//   drives mux_in from the channel values in chan_vals (bit n = channel n).
//   Inputs change and outputs are sampled 1 time unit after each rising edge;
//   "edge k" is the edge at which start/cont is first seen.
// -----------------------------------------------------------------------------
module tb_mux_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       cont;
    logic       sel_a;
    logic       sel_b;
    logic       mux_in;
    logic [3:0] scan_data;
    logic       scan_valid;
    logic       scan_ready;
    logic       busy;
    logic       overrun;
    logic [3:0] chan_vals;

    int checks_cnt;
    int fail_cnt;

    mux_scan_ctrl #(.SETTLE(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cont       (cont),
        .sel_a      (sel_a),
        .sel_b      (sel_b),
        .mux_in     (mux_in),
        .scan_data  (scan_data),
        .scan_valid (scan_valid),
        .scan_ready (scan_ready),
        .busy       (busy),
        .overrun    (overrun)
    );

    // Mux model: output follows the selected channel value
    assign mux_in = chan_vals[{sel_a, sel_b}];

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_idle_clear(input string tag);
        chk({tag, "_busy"},  8'(busy),       8'd0);
        chk({tag, "_valid"}, 8'(scan_valid), 8'd0);
        chk({tag, "_data"},  8'(scan_data),  8'd0);
        chk({tag, "_ovr"},   8'(overrun),    8'd0);
        chk({tag, "_sel"},   8'({sel_a, sel_b}), 8'd0);
    endtask

    initial begin
        checks_cnt = 0;
        fail_cnt   = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        cont       = 1'b0;
        scan_ready = 1'b0;
        chan_vals  = 4'b1101;

        // ---- initial reset ----
        tick_n(3);
        chk_idle_clear("rst0");
        rst_n = 1'b1;
        tick_n(2);
        chk_idle_clear("idle0");

        // ---- single scan: A=1 B=0 C=1 D=1 ----
        chan_vals = 4'b1101;
        start = 1'b1;
        tick();                     // edge k
        start = 1'b0;
        for (int j = 0; j < 12; j++) begin
            chk("single_sel", 8'({sel_a, sel_b}), 8'(j / 3));
            chk("single_busy", 8'(busy), 8'd1);
            chk("single_nv", 8'(scan_valid), 8'd0);
            tick();                 // edge k+j+1
        end
        // now after edge k+12
        chk("single_valid", 8'(scan_valid), 8'd1);
        chk("single_data",  8'(scan_data),  8'hD);
        chk("single_busy0", 8'(busy),       8'd0);
        chk("single_sel0",  8'({sel_a, sel_b}), 8'd0);
        tick();                     // k+13
        chk("single_hold", 8'(scan_valid), 8'd1);
        scan_ready = 1'b1;
        tick();                     // k+14
        scan_ready = 1'b0;
        chk("single_taken", 8'(scan_valid), 8'd0);
        chk("single_ovr",   8'(overrun),    8'd0);

        // ---- backpressure with cont, then reset mid-run ----
        cont = 1'b1;
        tick();                     // edge k
        tick_n(12);                 // k+12
        chk("bp_valid1", 8'(scan_valid), 8'd1);
        chk("bp_data1",  8'(scan_data),  8'hD);
        chk("bp_busy1",  8'(busy),       8'd1);
        tick_n(11);                 // k+23
        chk("bp_ovr_pre", 8'(overrun), 8'd0);
        tick();                     // k+24
        chk("bp_ovr",   8'(overrun),   8'd1);
        chk("bp_data2", 8'(scan_data), 8'hD);
        chk("bp_valid2", 8'(scan_valid), 8'd1);
        chk("bp_busy2", 8'(busy),      8'd1);
        tick_n(4);                  // k+28, mid-scan (ch1)
        chk("bp_sel_mid", 8'({sel_a, sel_b}), 8'd1);
        rst_n = 1'b0;
        tick();                     // first reset edge
        chk_idle_clear("rst_mid");
        tick_n(2);
        cont  = 1'b0;
        rst_n = 1'b1;
        tick_n(15);
        chk_idle_clear("rst_after");

        // ---- simultaneous completion and accept ----
        chan_vals = 4'b1101;
        cont = 1'b1;
        tick();                     // edge k
        tick_n(12);                 // k+12
        chk("sim_valid1", 8'(scan_valid), 8'd1);
        chk("sim_data1",  8'(scan_data),  8'hD);
        chan_vals = 4'b0110;
        tick_n(11);                 // k+23
        scan_ready = 1'b1;
        cont = 1'b0;
        tick();                     // k+24
        scan_ready = 1'b0;
        chk("sim_valid2", 8'(scan_valid), 8'd1);
        chk("sim_data2",  8'(scan_data),  8'h6);
        chk("sim_ovr",    8'(overrun),    8'd0);
        chk("sim_busy",   8'(busy),       8'd0);
        tick_n(3);
        chk("sim_idle", 8'(busy), 8'd0);
        scan_ready = 1'b1;
        tick();
        scan_ready = 1'b0;
        chk("sim_taken", 8'(scan_valid), 8'd0);

        // ---- ignored start during ch1, reset during ch2 settle ----
        chan_vals = 4'b1101;
        start = 1'b1;
        tick();                     // edge k
        start = 1'b0;
        tick_n(3);                  // k+3, ch1
        start = 1'b1;
        tick();                     // k+4
        start = 1'b0;
        chk("ign_sel4", 8'({sel_a, sel_b}), 8'd1);
        tick();                     // k+5
        chk("ign_sel5", 8'({sel_a, sel_b}), 8'd1);
        tick();                     // k+6
        chk("ign_sel6", 8'({sel_a, sel_b}), 8'd2);
        tick();                     // k+7, ch2 settle
        rst_n = 1'b0;
        tick();                     // k+8
        rst_n = 1'b1;
        chk_idle_clear("ign_rst");
        tick_n(15);
        chk_idle_clear("ign_after");

        // ---- sampling point on channel C ----
        chan_vals = 4'b0000;
        start = 1'b1;
        tick();                     // edge k
        start = 1'b0;
        tick_n(6);                  // k+6, ch2 settle begins
        chan_vals[2] = 1'b1;
        tick_n(3);                  // k+9, ch2 sample edge passed
        chk("samp_sel", 8'({sel_a, sel_b}), 8'd3);
        chan_vals[2] = 1'b0;
        tick_n(3);                  // k+12
        chk("samp_valid", 8'(scan_valid), 8'd1);
        chk("samp_data",  8'(scan_data),  8'h4);
        scan_ready = 1'b1;
        tick();
        scan_ready = 1'b0;
        chk("samp_taken", 8'(scan_valid), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
Sequencer that sits directly upstream and downstream of the team's 4-to-1 select mux (select inputs a/b, data inputs A..D, output out). It drives the mux select lines through all four channels in order. After a programmable settle time per channel, it samples the mux output and assembles the four samples into a 4-bit word. The word is presented on a valid/ready output interface, with optional continuous scanning and overrun detection.

Parameters:
SETTLE, 2, cycles each select value is held before the sampling cycle; legal range 1..255; elaboration error otherwise.

Ports:
clk  input  1  single system clock; all state updates on rising edge.
rst_n  input  1  synchronous reset, active-low (sampled on clk rising edge only).
start  input  1  single-scan request; sampled only in IDLE.
cont  input  1  continuous mode; scans back-to-back while high.
sel_a  output  1  to mux select "a" (MSB of channel index).
sel_b  output  1  to mux select "b" (LSB of channel index).
mux_in  input  1  from mux "out"; must be synchronous to clk.
scan_data  output  4  assembled word; bit n = sample of channel n (0=A, 1=B, 2=C, 3=D).
scan_valid  output  1  scan_data holds an unconsumed word.
scan_ready  input  1  consumer accepts the word at an edge where scan_valid=1.
busy  output  1  FSM not in IDLE.
overrun  output  1  sticky: a completed scan was dropped.

Behaviour:
- Reset, when rst_n=0 at an edge:
  - state IDLE, channel index ch=0, settle count=0, capture shadow=0.
  - scan_data=0, scan_valid=0, overrun=0, busy=0, sel_a=sel_b=0.
  - Reset mid-scan abandons the partial word; no output is produced for it.
- Select outputs: sel_a=ch[1], sel_b=ch[0], decoded from the registered ch with no extra delay. ch=0 in IDLE.
- FSM states: IDLE, SETTLE, SAMPLE.
  - IDLE: if (start|cont) at an edge -> SETTLE, with ch=0 and count=0. Otherwise stay.
  - SETTLE: count increments each cycle. At the edge where count==SETTLE-1 -> SAMPLE.
  - SAMPLE (1 cycle): at its closing edge, shadow[ch] <= mux_in.
    - If ch<3: ch<=ch+1, count=0, -> SETTLE.
    - If ch==3: word completes (see output rules). Then, if cont=1 at that edge -> SETTLE with ch=0; else -> IDLE with ch=0.
- Per-channel time is SETTLE+1 cycles.
- Latency: if start is accepted at edge k, the word completes at edge k+4*(SETTLE+1). scan_valid is high from that edge. With SETTLE=2, that is edge k+12.
- start or cont pulses while busy are ignored; there is no queueing.
- Completing word at ch3: the completing sample bit and shadow[2:0] form the new word W.
  - If scan_valid=0, or scan_valid=1 and scan_ready=1 at that same edge: scan_data<=W and scan_valid<=1.
  - If scan_valid=1 and scan_ready=0: W is dropped, scan_data is unchanged, overrun<=1.
- Output handshake:
  - scan_data is stable while scan_valid=1.
  - Transfer occurs at an edge with scan_valid=1 and scan_ready=1. scan_valid then clears at that edge unless a new word completes at the same edge (rule above).
  - scan_ready while scan_valid=0 has no effect.
- overrun clears only on reset.
- busy=1 in SETTLE and SAMPLE. busy=0 in IDLE, including when scan_valid=1 is pending.
- Only the value of mux_in at the SAMPLE closing edge is captured; changes during SETTLE are ignored.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles mid-run -> all outputs 0 and sel_a/sel_b=00 from the first reset edge; no scan_valid afterwards until a new start.
- Single scan (SETTLE=2): model the mux with A=1, B=0, C=1, D=1 and pulse start at edge k -> sel sequence 00,01,10,11, 3 cycles each; scan_valid rises at edge k+12 with scan_data=4'b1101; busy=0 from edge k+12; scan_ready=1 at edge k+14 -> scan_valid=0 after edge k+14.
- Backpressure with cont=1 and scan_ready=0: first word 4'b1101 held; second completion at edge k+24 -> overrun=1, scan_data still 4'b1101, scanning continues.
- Simultaneous completion and accept: cont=1, inputs changed to 4'b0110 (B=C=1) before the second scan, scan_ready=1 only at edge k+24 -> scan_valid stays 1, scan_data=4'b0110, overrun=0.
- Ignored start / reset mid-scan: start pulses during ch1 -> no effect on sequence; rst_n=0 during ch2 SETTLE -> next cycle IDLE, sel 00, scan_valid=0, no word emitted.
- Sampling point: toggle C 0->1 during ch2 SETTLE, then 1->0 exactly after the ch2 SAMPLE edge -> scan_data[2]=1.
